pipeline_hazard_ctrl: RTL and testbench

- Central stall/flush/forwarding controller for the five-stage pipeline.
- Drives the hold and bubble controls of the IF/ID, ID/EXE and EXE/MEM pipeline registers.
- Handles load-use interlock, EX-stage redirect (taken branch, JR, jal) and multi-cycle multiply/divide occupancy of EX.
- Produces EX-stage operand forwarding selects and a saturating stall-cycle performance counter.

---
 rtl/pipe_ctrl_pkg.sv | 14 +
 rtl/fwd_sel.sv | 29 ++
 rtl/pipeline_hazard_ctrl.sv | 144 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states and
// EX operand forward-select codes.
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MDU_WAIT = 1'b1
    } state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/fwd_sel.sv
// Single-operand EX forward select: the MEM result beats the WB result, and
// register 0 is never forwarded.
module fwd_sel
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] i_src,
    input  logic       i_regwrite_m,
    input  logic [4:0] i_writereg_m,
    input  logic       i_regwrite_w,
    input  logic [4:0] i_writereg_w,
    output logic [1:0] o_fwd
);

    logic w_hit_m;
    logic w_hit_w;

    assign w_hit_m = i_regwrite_m && (i_writereg_m != 5'd0) && (i_writereg_m == i_src);
    assign w_hit_w = i_regwrite_w && (i_writereg_w != 5'd0) && (i_writereg_w == i_src);

    always_comb begin
        o_fwd = FWD_RF;
        if (w_hit_m) begin
            o_fwd = FWD_MEM;
        end else if (w_hit_w) begin
            o_fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forwarding controller for the five-stage pipeline: load-use
// interlock, EX redirect flush, multi-cycle MDU occupancy and stall counter.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MDU_CYCLES = 4,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [4:0]       rsD,
    input  logic [4:0]       rtD,
    input  logic [4:0]       rsE,
    input  logic [4:0]       rtE,
    input  logic [4:0]       writeregE,
    input  logic [4:0]       writeregM,
    input  logic [4:0]       writeregW,
    input  logic             regwriteE,
    input  logic             regwriteM,
    input  logic             regwriteW,
    input  logic             memtoregE,
    input  logic             redirectE,
    input  logic             mduE,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             flushD,
    output logic             flushE,
    output logic             flushM,
    output logic [1:0]       fwdAE,
    output logic [1:0]       fwdBE,
    output logic             mdu_busy,
    output logic             mdu_done,
    output logic [CNT_W-1:0] stall_cnt
);

    // First MDU cycle is spent in RUN, so MDU_WAIT counts down from MDU_CYCLES-2.
    localparam logic [3:0]       MDU_LOAD = 4'(MDU_CYCLES - 2);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           r_state;
    state_e           w_state_d;
    logic [3:0]       r_mdu_cnt;
    logic [3:0]       w_mdu_cnt_d;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_lu;
    logic w_stall_f, w_stall_d, w_stall_e;
    logic w_flush_d, w_flush_e, w_flush_m;
    logic w_busy, w_done;

    fwd_sel u_fwd_a (
        .i_src        (rsE),
        .i_regwrite_m (regwriteM),
        .i_writereg_m (writeregM),
        .i_regwrite_w (regwriteW),
        .i_writereg_w (writeregW),
        .o_fwd        (fwdAE)
    );

    fwd_sel u_fwd_b (
        .i_src        (rtE),
        .i_regwrite_m (regwriteM),
        .i_writereg_m (writeregM),
        .i_regwrite_w (regwriteW),
        .i_writereg_w (writeregW),
        .o_fwd        (fwdBE)
    );

    assign w_lu = memtoregE && regwriteE && (writeregE != 5'd0) &&
                  ((writeregE == rsD) || (writeregE == rtD));

    always_comb begin
        w_state_d   = r_state;
        w_mdu_cnt_d = r_mdu_cnt;
        w_stall_f   = 1'b0;
        w_stall_d   = 1'b0;
        w_stall_e   = 1'b0;
        w_flush_d   = 1'b0;
        w_flush_e   = 1'b0;
        w_flush_m   = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        unique case (r_state)
            RUN: begin
                if (redirectE) begin
                    w_flush_d = 1'b1;
                    w_flush_e = 1'b1;
                end else if (mduE) begin
                    w_state_d   = MDU_WAIT;
                    w_mdu_cnt_d = MDU_LOAD;
                    w_stall_f   = 1'b1;
                    w_stall_d   = 1'b1;
                    w_stall_e   = 1'b1;
                    w_flush_m   = 1'b1;
                end else if (w_lu) begin
                    w_stall_f = 1'b1;
                    w_stall_d = 1'b1;
                    w_flush_e = 1'b1;
                end
            end
            MDU_WAIT: begin
                w_busy = 1'b1;
                if (r_mdu_cnt == 4'd0) begin
                    w_done    = 1'b1;
                    w_state_d = RUN;
                end else begin
                    w_mdu_cnt_d = r_mdu_cnt - 4'd1;
                    w_stall_f   = 1'b1;
                    w_stall_d   = 1'b1;
                    w_stall_e   = 1'b1;
                    w_flush_m   = 1'b1;
                end
            end
            default: w_state_d = RUN;
        endcase
    end

    // Controls drop asynchronously with clr, even when inputs still request a stall.
    assign stallF    = w_stall_f & clr;
    assign stallD    = w_stall_d & clr;
    assign stallE    = w_stall_e & clr;
    assign flushD    = w_flush_d & clr;
    assign flushE    = w_flush_e & clr;
    assign flushM    = w_flush_m & clr;
    assign mdu_busy  = w_busy & clr;
    assign mdu_done  = w_done & clr;
    assign stall_cnt = r_stall_cnt;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state     <= RUN;
            r_mdu_cnt   <= 4'd0;
            r_stall_cnt <= '0;
        end else begin
            r_state   <= w_state_d;
            r_mdu_cnt <= w_mdu_cnt_d;
            if (stallF && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: forwarding, load-use, redirect,
// MDU occupancy, mid-MDU reset and counter saturation (CNT_W=4 instance).
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic       regwriteE, regwriteM, regwriteW, memtoregE, redirectE, mduE;

    logic        stallF, stallD, stallE, flushD, flushE, flushM, mdu_busy, mdu_done;
    logic [1:0]  fwdAE, fwdBE;
    logic [31:0] stall_cnt;

    logic       s_stallF, s_stallD, s_stallE, s_flushD, s_flushE, s_flushM;
    logic       s_busy, s_done;
    logic [1:0] s_fwdAE, s_fwdBE;
    logic [3:0] s_stall_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MDU_CYCLES(4), .CNT_W(32)) dut (
        .clk(clk), .clr(clr), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .redirectE(redirectE), .mduE(mduE),
        .stallF(stallF), .stallD(stallD), .stallE(stallE),
        .flushD(flushD), .flushE(flushE), .flushM(flushM),
        .fwdAE(fwdAE), .fwdBE(fwdBE), .mdu_busy(mdu_busy), .mdu_done(mdu_done),
        .stall_cnt(stall_cnt)
    );

    pipeline_hazard_ctrl #(.MDU_CYCLES(4), .CNT_W(4)) dut_sat (
        .clk(clk), .clr(clr), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .redirectE(redirectE), .mduE(mduE),
        .stallF(s_stallF), .stallD(s_stallD), .stallE(s_stallE),
        .flushD(s_flushD), .flushE(s_flushE), .flushM(s_flushM),
        .fwdAE(s_fwdAE), .fwdBE(s_fwdBE), .mdu_busy(s_busy), .mdu_done(s_done),
        .stall_cnt(s_stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {stallF, stallD, stallE, flushD, flushE, flushM, mdu_busy, mdu_done}
    function automatic logic [7:0] ctl();
        return {stallF, stallD, stallE, flushD, flushE, flushM, mdu_busy, mdu_done};
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_lu(input logic on);
        memtoregE = on;
        regwriteE = on;
        writeregE = 5'd8;
        rtD       = 5'd8;
    endtask

    initial begin
        rsD = 5'd0; rtD = 5'd0; rsE = 5'd0; rtE = 5'd0;
        writeregE = 5'd0; writeregM = 5'd0; writeregW = 5'd0;
        regwriteE = 1'b0; regwriteM = 1'b0; regwriteW = 1'b0;
        memtoregE = 1'b0; redirectE = 1'b0; mduE = 1'b0;

        // Reset holds everything low, even with a load-use pending.
        set_lu(1'b1);
        #1;
        chk("reset_ctl", 32'(ctl()), 32'h00);
        chk("reset_cnt", stall_cnt, 32'd0);
        chk("reset_cnt_sat", 32'(s_stall_cnt), 32'd0);
        set_lu(1'b0);
        step();
        clr = 1'b1;
        #1;
        chk("idle_ctl", 32'(ctl()), 32'h00);

        // Forwarding priority and r0 suppression.
        step();
        regwriteM = 1'b1; writeregM = 5'd5; regwriteW = 1'b1; writeregW = 5'd5;
        rsE = 5'd5; rtE = 5'd7;
        #1;
        chk("fwdA_mem", 32'(fwdAE), 32'h2);
        chk("fwdB_none", 32'(fwdBE), 32'h0);
        regwriteM = 1'b0;
        #1;
        chk("fwdA_wb", 32'(fwdAE), 32'h1);
        writeregW = 5'd7; regwriteM = 1'b1; writeregM = 5'd5;
        #1;
        chk("fwdB_wb", 32'(fwdBE), 32'h1);
        writeregM = 5'd0; writeregW = 5'd0; rsE = 5'd0;
        #1;
        chk("fwdA_r0", 32'(fwdAE), 32'h0);
        regwriteM = 1'b0; regwriteW = 1'b0;

        // Load-use: one bubble cycle.
        step();
        set_lu(1'b1);
        #1;
        chk("lu_ctl", 32'(ctl()), 32'b1100_1000);
        step();
        set_lu(1'b0);
        #1;
        chk("lu_after_ctl", 32'(ctl()), 32'h00);
        chk("lu_cnt", stall_cnt, 32'd1);

        // Redirect beats load-use, no stall counted.
        step();
        set_lu(1'b1);
        redirectE = 1'b1;
        #1;
        chk("redir_ctl", 32'(ctl()), 32'b0001_1000);
        step();
        set_lu(1'b0);
        redirectE = 1'b0;
        #1;
        chk("redir_cnt", stall_cnt, 32'd1);

        // MDU occupancy, 4 cycles; mduE held while the op sits in EX.
        step();
        mduE = 1'b1;
        #1;
        chk("mdu_c0", 32'(ctl()), 32'b1110_0100);
        step();
        #1;
        chk("mdu_c1", 32'(ctl()), 32'b1110_0110);
        step();
        #1;
        chk("mdu_c2", 32'(ctl()), 32'b1110_0110);
        step();
        #1;
        chk("mdu_c3", 32'(ctl()), 32'b0000_0011);
        step();
        mduE = 1'b0;
        #1;
        chk("mdu_c4", 32'(ctl()), 32'h00);
        chk("mdu_cnt", stall_cnt, 32'd4);

        // Reset during the second MDU_WAIT cycle.
        step();
        mduE = 1'b1;
        step();
        step();
        #1;
        chk("mdu_rst_pre", 32'(ctl()), 32'b1110_0110);
        clr = 1'b0;
        #1;
        chk("mdu_rst_ctl", 32'(ctl()), 32'h00);
        chk("mdu_rst_cnt", stall_cnt, 32'd0);
        step();
        clr = 1'b1;
        mduE = 1'b0;
        #1;
        chk("mdu_rst_after", 32'(ctl()), 32'h00);
        step();
        #1;
        chk("mdu_rst_run", 32'(ctl()), 32'h00);
        chk("mdu_rst_cnt2", stall_cnt, 32'd0);

        // Saturation: 20 load-use cycles; 4-bit counter stops at 15.
        set_lu(1'b1);
        for (int i = 0; i < 20; i++) begin
            step();
        end
        set_lu(1'b0);
        #1;
        chk("sat_cnt4", 32'(s_stall_cnt), 32'd15);
        chk("sat_cnt32", stall_cnt, 32'd20);
        step();
        #1;
        chk("sat_hold", 32'(s_stall_cnt), 32'd15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
